// File: rtl/spi_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_frame_pkg                                              |
// | Brief   : Shared types, frame geometry helpers and MISO idle level.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic c_MISO_IDLE = 1'b1;

    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int rw_bit_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int addr_lsb_pos(input int data_w);
        return data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_input_sync                                             |
// | Brief   : Multi-flop synchroniser with rise/fall detection.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_stages;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stages <= {SYNC_STAGES{RST_VAL}};
            r_prev   <= RST_VAL;
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_din};
            r_prev   <= r_stages[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];
    assign o_rise = r_stages[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_stages[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_frame_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_frame_slave                                            |
// | Brief   : Oversampled mode-3 SPI slave writing an addressed bank.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_frame_slave
    import spi_frame_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 12,
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       spi_sclk_i,
    input  logic                       spi_ss_i,
    input  logic                       spi_mosi_i,
    output logic                       spi_miso_o,
    output logic [NUM_REGS*DATA_W-1:0] reg_data_o,
    output logic                       wr_strobe_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic                       frame_err_o
);

    localparam int c_FRAME_W  = frame_width(ADDR_W, DATA_W);
    localparam int c_RW_BIT   = rw_bit_pos(ADDR_W, DATA_W);
    localparam int c_ADDR_LSB = addr_lsb_pos(DATA_W);
    localparam int c_CNT_W    = $clog2(c_FRAME_W + 2);

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_FRAME_W);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_FRAME_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HDR  = c_CNT_W'(ADDR_W);

    logic w_sclk_rise, w_sclk_fall, w_sclk_lvl_unused;
    logic w_ss_rise, w_ss_fall, w_ss_lvl_unused;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk(clock_i), .rst(reset_i), .i_din(spi_sclk_i),
        .o_sync(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clock_i), .rst(reset_i), .i_din(spi_ss_i),
        .o_sync(w_ss_lvl_unused), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
        .clk(clock_i), .rst(reset_i), .i_din(spi_mosi_i),
        .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_FRAME_W-1:0]  r_shift;
    logic [DATA_W-1:0]     r_rd_shift;
    logic                  r_rd_active;
    logic                  r_ss_pend;
    logic                  r_miso;
    logic [DATA_W-1:0]     r_regs [NUM_REGS];
    logic                  r_wr_strobe;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic                  r_frame_err;

    logic [c_FRAME_W-1:0]  w_shift_next;
    logic                  w_hdr_rw;
    logic [ADDR_W-1:0]     w_hdr_addr;
    logic [DATA_W-1:0]     w_rd_word;
    logic                  w_rw;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_data;
    logic                  w_addr_ok;

    // Header fields are taken from the value being shifted in, so the read
    // word is ready before the first data-phase SCLK fall.
    assign w_shift_next = {r_shift[c_FRAME_W-2:0], w_mosi};
    assign w_hdr_rw     = w_shift_next[ADDR_W];
    assign w_hdr_addr   = w_shift_next[ADDR_W-1:0];

    assign w_rw      = r_shift[c_RW_BIT];
    assign w_addr    = r_shift[c_ADDR_LSB +: ADDR_W];
    assign w_data    = r_shift[DATA_W-1:0];
    assign w_addr_ok = (int'(w_addr) < NUM_REGS);

    // Unimplemented addresses fall through to zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hdr_addr == ADDR_W'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rd_shift  <= '0;
            r_rd_active <= 1'b0;
            r_ss_pend   <= 1'b0;
            r_miso      <= c_MISO_IDLE;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_miso      <= c_MISO_IDLE;
                    r_rd_active <= 1'b0;
                    if (w_ss_fall || r_ss_pend) begin
                        r_state   <= ST_SHIFT;
                        r_cnt     <= '0;
                        r_shift   <= '0;
                        r_ss_pend <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_ss_rise) begin
                        r_state <= ST_DONE;
                    end else begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_next;
                            if (r_cnt != c_CNT_SAT) begin
                                r_cnt <= r_cnt + c_CNT_W'(1);
                            end
                            if (r_cnt == c_CNT_HDR && w_hdr_rw) begin
                                r_rd_active <= 1'b1;
                                r_rd_shift  <= w_rd_word;
                            end
                        end
                        if (w_sclk_fall && r_rd_active) begin
                            r_miso     <= r_rd_shift[DATA_W-1];
                            r_rd_shift <= {r_rd_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_miso      <= c_MISO_IDLE;
                    r_rd_active <= 1'b0;
                    if (w_ss_fall) begin
                        r_ss_pend <= 1'b1;
                    end
                    if (r_cnt != c_CNT_FULL) begin
                        r_frame_err <= 1'b1;
                    end else if (!w_rw) begin
                        if (w_addr_ok) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (w_addr == ADDR_W'(i)) begin
                                    r_regs[i] <= w_data;
                                end
                            end
                            r_wr_strobe <= 1'b1;
                            r_wr_addr   <= w_addr;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_flat
            assign reg_data_o[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign spi_miso_o  = r_miso;
    assign wr_strobe_o = r_wr_strobe;
    assign wr_addr_o   = r_wr_addr;
    assign frame_err_o = r_frame_err;

endmodule
`default_nettype wire
